trig_capture_mc: RTL

- Parametrised multi-channel triggered sample store.
- Accepts a tagged sample stream from the modular ADC sequencer, keeps a circular pre-trigger history and captures a programmable post-trigger window.
- Flags completion on `complete` and exposes control, status and the captured window, oldest sample first, on an Avalon-MM slave reached through the SPI-to-Avalon bridge.
- Successor to the single-channel fixed-depth triggered storage: adds channel count, depth, channel masking, a level/edge trigger, pre-trigger length and abort.

---
 rtl/trig_capture_pkg.sv | 24 ++
 rtl/tcm_dpram.sv | 19 +
 rtl/trig_capture_mc.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/trig_capture_pkg.sv
// trig_capture_pkg: shared states, register map, trigger modes and control bits for trig_capture_mc.
package trig_capture_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam int REG_CTRL      = 0;
  localparam int REG_STATUS    = 1;
  localparam int REG_TRIG_CFG  = 2;
  localparam int REG_THRESHOLD = 3;
  localparam int REG_PRE_LEN   = 4;
  localparam int REG_CH_MASK   = 5;
  localparam int REG_TRIG_POS  = 6;
  localparam logic [1:0] MODE_FORCE = 2'd0;
  localparam logic [1:0] MODE_RISE  = 2'd1;
  localparam logic [1:0] MODE_FALL  = 2'd2;
  localparam logic [1:0] MODE_EXT   = 2'd3;
  localparam int CTRL_ARM   = 0;
  localparam int CTRL_FORCE = 1;
  localparam int CTRL_ABORT = 2;
endpackage

// File: rtl/tcm_dpram.sv
// tcm_dpram: simple dual-port sample RAM, one write port, registered read port (1-cycle latency).
module tcm_dpram #(
  parameter int W     = 15,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/trig_capture_mc.sv
// trig_capture_mc: multi-channel triggered sample store with circular pre-trigger history and Avalon-MM access.
module trig_capture_mc
  import trig_capture_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int CH_W   = 3,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snk_valid,
  input  logic [CH_W-1:0]   snk_channel,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              ext_trig,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              complete
);
  localparam int AW  = ADDR_W - 1;
  localparam int NCH = 1 << CH_W;
  state_t              state;
  logic [AW-1:0]       wr_ptr, start_ptr, trig_pos, pre_len, trig_idx, rd_addr;
  logic [ADDR_W-1:0]   count, post_cnt, pre_after, post_after, post_len;
  logic [DATA_W-1:0]   thr, prev;
  logic                prev_valid;
  logic [1:0]          mode;
  logic [CH_W-1:0]     trig_ch;
  logic [NCH-1:0]      ch_mask;
  logic                ctrl_wr, arm, abort, frc, cfg_ok, capturing, store, is_tch, rise, fall, trig;
  logic                rd_q, buf_q;
  logic [31:0]         reg_rd, reg_q;
  logic [CH_W+DATA_W-1:0] ram_q;
  assign ctrl_wr   = avs_write && avs_address == ADDR_W'(REG_CTRL);
  assign abort     = ctrl_wr && avs_writedata[CTRL_ABORT];
  assign arm       = ctrl_wr && avs_writedata[CTRL_ARM] && !abort;
  assign frc       = ctrl_wr && avs_writedata[CTRL_FORCE] && !avs_writedata[CTRL_ARM] && !abort;
  assign cfg_ok    = state == S_IDLE || state == S_DONE;
  assign capturing = (state == S_PRE || state == S_ARMED || state == S_POST) && !arm && !abort;
  assign store     = capturing && snk_valid && ch_mask[snk_channel];
  assign is_tch    = capturing && snk_valid && snk_channel == trig_ch;
  assign rise      = is_tch && prev_valid && prev < thr && snk_data >= thr;
  assign fall      = is_tch && prev_valid && prev >= thr && snk_data < thr;
  // Edge triggers need the sample to land in the buffer; ext/force may fire on an empty cycle.
  assign trig      = state == S_ARMED && !arm && !abort &&
                     (frc || (mode == MODE_EXT && ext_trig) ||
                      (store && ((mode == MODE_RISE && rise) || (mode == MODE_FALL && fall))));
  assign trig_idx  = store ? wr_ptr : wr_ptr - AW'(1);
  assign pre_after  = count + ADDR_W'(store);
  assign post_after = post_cnt + ADDR_W'(store);
  assign post_len   = ADDR_W'(DEPTH - 1) - ADDR_W'(pre_len);
  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= MODE_FORCE;
      trig_ch <= '0;
      thr     <= '0;
      pre_len <= '0;
      ch_mask <= '1;
    end else if (avs_write && cfg_ok) begin
      if (avs_address == ADDR_W'(REG_TRIG_CFG)) begin
        mode    <= avs_writedata[1:0];
        trig_ch <= avs_writedata[4 +: CH_W];
      end
      if (avs_address == ADDR_W'(REG_THRESHOLD)) thr <= avs_writedata[DATA_W-1:0];
      if (avs_address == ADDR_W'(REG_PRE_LEN))
        pre_len <= avs_writedata > 32'(DEPTH - 1) ? AW'(DEPTH - 1) : avs_writedata[AW-1:0];
      if (avs_address == ADDR_W'(REG_CH_MASK)) ch_mask <= avs_writedata[NCH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      start_ptr  <= '0;
      trig_pos   <= '0;
      count      <= '0;
      post_cnt   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      complete   <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (store && count != ADDR_W'(DEPTH)) count <= count + ADDR_W'(1);
      if (is_tch) begin
        prev       <= snk_data;
        prev_valid <= 1'b1;
      end
      if (abort) begin
        state    <= S_IDLE;
        complete <= 1'b0;
      end else if (arm) begin
        state      <= S_PRE;
        wr_ptr     <= '0;
        count      <= '0;
        post_cnt   <= '0;
        prev_valid <= 1'b0;
        complete   <= 1'b0;
      end else if (state == S_PRE && pre_after >= ADDR_W'(pre_len)) begin
        state <= S_ARMED;
      end else if (trig) begin
        state     <= S_POST;
        trig_pos  <= trig_idx;
        start_ptr <= trig_idx - pre_len;
        post_cnt  <= '0;
      end else if (state == S_POST) begin
        post_cnt <= post_after;
        if (post_after >= post_len) begin
          state    <= S_DONE;
          complete <= 1'b1;
        end
      end
    end
  end
  assign rd_addr = start_ptr + avs_address[AW-1:0];
  tcm_dpram #(.W(CH_W + DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata ({snk_channel, snk_data}),
    .raddr (rd_addr),
    .rdata (ram_q)
  );
  assign reg_rd = avs_address == ADDR_W'(REG_STATUS)    ? {16'(count), 12'd0, complete, state} :
                  avs_address == ADDR_W'(REG_TRIG_CFG)  ? 32'({trig_ch, 2'b00, mode}) :
                  avs_address == ADDR_W'(REG_THRESHOLD) ? 32'(thr) :
                  avs_address == ADDR_W'(REG_PRE_LEN)   ? 32'(pre_len) :
                  avs_address == ADDR_W'(REG_CH_MASK)   ? 32'(ch_mask) :
                  avs_address == ADDR_W'(REG_TRIG_POS)  ? 32'(trig_pos) : 32'd0;
  // Stage one is the RAM/register capture, stage two this output mux register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q              <= 1'b0;
      buf_q             <= 1'b0;
      reg_q             <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      rd_q              <= avs_read;
      buf_q             <= avs_address[AW];
      reg_q             <= reg_rd;
      avs_readdatavalid <= rd_q;
      if (rd_q) avs_readdata <= buf_q ? {16'(ram_q[DATA_W +: CH_W]), 16'(ram_q[DATA_W-1:0])} : reg_q;
    end
  end
endmodule
